// File: rtl/axi_beat_pkg.sv
// Shared types for the AXI per-beat address sequencer.
// Burst encodings, sequencer states and the 4 KB page size.
package axi_beat_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } axi_burst_t;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } seq_state_t;

  localparam int AXI_4K_BYTES = 4096;

  // Only these lengths form a legal AXI wrapping burst.
  function automatic logic wrap_len_ok(input int unsigned len);
    return (len == 1) || (len == 3) || (len == 7) || (len == 15);
  endfunction

endpackage

// File: rtl/axi_gen_addr.sv
// Combinational next-beat address for FIXED / INCR / WRAP bursts.
// INCR rolls over modulo 2^AW; WRAP stays inside the (len+1)<<size window.
module axi_gen_addr
  import axi_beat_pkg::*;
#(
  parameter int AW  = 32,
  parameter int ODW = 32,
  parameter int LEN = 8
) (
  input  logic [AW-1:0]  i_addr,
  input  logic [LEN-1:0] i_len,
  input  logic [2:0]     i_size,
  input  axi_burst_t     i_burst,
  output logic [AW-1:0]  o_next_addr
);

  logic [AW-1:0] w_step;
  logic [AW-1:0] w_incr;
  logic [AW-1:0] w_wrap_mask;

  assign w_step      = AW'(1) << i_size;
  assign w_incr      = i_addr + w_step;
  assign w_wrap_mask = ((AW'(i_len) + AW'(1)) << i_size) - AW'(1);

  always_comb begin
    o_next_addr = w_incr;
    unique case (i_burst)
      BURST_FIXED: o_next_addr = i_addr;
      BURST_WRAP:  o_next_addr = (i_addr & ~w_wrap_mask)
                               | (w_incr & w_wrap_mask);
      default:     o_next_addr = w_incr;
    endcase
  end

  // The downstream port must carry whole bytes.
  generate
    if (ODW < 8 || (ODW % 8) != 0) begin : g_bad_odw
      $error("axi_gen_addr: ODW must be a multiple of 8");
    end
  endgenerate

endmodule

// File: rtl/axi_beat_sequencer.sv
// Per-beat address sequencer for one AXI AR/AW channel.
// Optional 4 KB crossing flag: define AXI_BEAT_SEQ_4K_CHK_EN.
module axi_beat_sequencer
  import axi_beat_pkg::*;
#(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int ODW = 32,
  parameter int LEN = 8
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_cmd_valid,
  output logic           o_cmd_ready,
  input  logic [AW-1:0]  i_cmd_addr,
  input  logic [LEN-1:0] i_cmd_len,
  input  logic [2:0]     i_cmd_size,
  input  logic [1:0]     i_cmd_burst,
  output logic           o_beat_valid,
  input  logic           i_beat_ready,
  output logic [AW-1:0]  o_beat_addr,
  output logic [LEN-1:0] o_beat_idx,
  output logic           o_beat_last,
  output logic           o_busy
`ifdef AXI_BEAT_SEQ_4K_CHK_EN
  ,
  output logic           o_err_4k
`endif
);

  localparam int         SZ_MAX   = $clog2(DW / 8);
  localparam logic [2:0] SZ_MAX_L = 3'(SZ_MAX);

  seq_state_t     r_state;
  seq_state_t     w_state_nxt;
  logic [LEN-1:0] r_len;
  logic [LEN-1:0] r_idx;
  logic [2:0]     r_size;
  axi_burst_t     r_burst;
  logic           r_beat_valid;
  logic           r_beat_last;
  logic [AW-1:0]  r_beat_addr;

  logic           w_cmd_fire;
  logic           w_beat_fire;
  logic           w_last_fire;
  logic [2:0]     w_size_c;
  axi_burst_t     w_burst_c;
  logic [AW-1:0]  w_next_addr;
  logic [LEN-1:0] w_idx_inc;

  assign w_beat_fire = r_beat_valid & i_beat_ready;
  assign w_last_fire = w_beat_fire & r_beat_last;
  // Ready rises with the final beat so bursts chain without a bubble.
  assign o_cmd_ready = ~i_rst
                     & ((r_state == S_IDLE) | w_last_fire);
  assign w_cmd_fire  = i_cmd_valid & o_cmd_ready;
  assign w_idx_inc   = r_idx + LEN'(1);

  assign w_size_c = (i_cmd_size > SZ_MAX_L) ? SZ_MAX_L
                                            : i_cmd_size;

  always_comb begin
    w_burst_c = BURST_INCR;
    unique case (i_cmd_burst)
      2'b00:   w_burst_c = BURST_FIXED;
      2'b10:   w_burst_c = wrap_len_ok(32'(i_cmd_len))
                         ? BURST_WRAP : BURST_INCR;
      default: w_burst_c = BURST_INCR;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_cmd_fire) w_state_nxt = S_BURST;
      end
      S_BURST: begin
        if (w_last_fire && !w_cmd_fire) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  axi_gen_addr #(
    .AW  (AW),
    .ODW (ODW),
    .LEN (LEN)
  ) u_gen_addr (
    .i_addr      (r_beat_addr),
    .i_len       (r_len),
    .i_size      (r_size),
    .i_burst     (r_burst),
    .o_next_addr (w_next_addr)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_beat_valid <= 1'b0;
      r_beat_last  <= 1'b0;
      r_beat_addr  <= '0;
      r_idx        <= '0;
      r_len        <= '0;
      r_size       <= '0;
      r_burst      <= BURST_INCR;
    end else if (w_cmd_fire) begin
      r_beat_valid <= 1'b1;
      r_beat_addr  <= i_cmd_addr;
      r_idx        <= '0;
      r_beat_last  <= (i_cmd_len == '0);
      r_len        <= i_cmd_len;
      r_size       <= w_size_c;
      r_burst      <= w_burst_c;
    end else if (w_last_fire) begin
      r_beat_valid <= 1'b0;
      r_beat_last  <= 1'b0;
    end else if (w_beat_fire) begin
      r_beat_addr  <= w_next_addr;
      r_idx        <= w_idx_inc;
      r_beat_last  <= (w_idx_inc == r_len);
    end
  end

  assign o_beat_valid = r_beat_valid;
  assign o_beat_addr  = r_beat_addr;
  assign o_beat_idx   = r_idx;
  assign o_beat_last  = r_beat_last;
  assign o_busy       = (r_state == S_BURST);

`ifdef AXI_BEAT_SEQ_4K_CHK_EN
  localparam int PG = $clog2(AXI_4K_BYTES);

  logic [AW-1:0] w_bytes;
  logic [AW-1:0] w_end;
  logic          w_cross;
  logic          r_err_4k;

  assign w_bytes = (AW'(i_cmd_len) + AW'(1)) << w_size_c;
  assign w_end   = i_cmd_addr + w_bytes - AW'(1);
  assign w_cross = (w_burst_c == BURST_INCR)
                 & (w_end[AW-1:PG] != i_cmd_addr[AW-1:PG]);

  // Flag only; the burst still runs exactly as commanded.
  always_ff @(posedge i_clk) begin
    if (i_rst)            r_err_4k <= 1'b0;
    else if (w_cmd_fire)  r_err_4k <= w_cross;
    else if (w_last_fire) r_err_4k <= 1'b0;
  end

  assign o_err_4k = r_err_4k;
`endif

endmodule
